// File: rtl/rf_scoreboard_pkg.sv
// rf_scoreboard_pkg: shared register-file scoreboard constants and write-back bus layout.
package rf_scoreboard_pkg;
  localparam int NREG      = 32;
  localparam int CNT_W_DEF = 2;
  localparam int WB_BUS_W  = 38;
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_bus_t;
  function automatic logic [4:0] wb_dest(input wb_bus_t b);
    return b.waddr;
  endfunction
endpackage

// File: rtl/rf_sb_counter.sv
// rf_sb_counter: saturating up/down pending-write counter with clear and underflow pulse.
module rf_sb_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         uflow_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0
          : (inc_i && !dec_i && cnt_q != '1) ? cnt_q + W'(1)
          : (dec_i && !inc_i && cnt_q != '0) ? cnt_q - W'(1)
          : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  // a retire the scoreboard never saw issue; a flush cancels it silently
  assign uflow_o = dec_i && !clr_i && cnt_q == '0;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-GPR pending-write scoreboard that stalls decode on pending sources.
// Optional RF_SB_BYPASS_EN lets a source retiring this cycle bypass from write-back.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid_i,
  input  logic            issue_we_i,
  input  logic [4:0]      issue_dest_i,
  input  logic [4:0]      rs_addr_i,
  input  logic            rs_used_i,
  input  logic [4:0]      rt_addr_i,
  input  logic            rt_used_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_dest_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [NREG-1:0] busy_mask_o,
`ifdef RF_SB_BYPASS_EN
  output logic            bypass_rs_o,
  output logic            bypass_rt_o,
`endif
  output logic            sb_error_o
);
  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  uflow;
  logic             pend_rs, pend_rt, full, fire, sb_error_q;
  genvar i;
  for (i = 0; i < NREG; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign cnt[i]   = '0;
      assign uflow[i] = 1'b0;
    end else begin : g_cnt
      rf_sb_counter #(.W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (fire && issue_dest_i == 5'(i)),
        .dec_i   (wb_we_i && wb_dest_i == 5'(i)),
        .clr_i   (flush_i),
        .cnt_o   (cnt[i]),
        .uflow_o (uflow[i])
      );
    end
    assign busy_mask_o[i] = |cnt[i];
  end
`ifdef RF_SB_BYPASS_EN
  // only the last outstanding write may be forwarded, older ones are still in flight
  assign bypass_rs_o = rs_used_i && rs_addr_i != '0 && cnt[rs_addr_i] == CNT_W'(1) && wb_we_i && wb_dest_i == rs_addr_i;
  assign bypass_rt_o = rt_used_i && rt_addr_i != '0 && cnt[rt_addr_i] == CNT_W'(1) && wb_we_i && wb_dest_i == rt_addr_i;
  assign pend_rs = rs_used_i && rs_addr_i != '0 && cnt[rs_addr_i] != '0 && !bypass_rs_o;
  assign pend_rt = rt_used_i && rt_addr_i != '0 && cnt[rt_addr_i] != '0 && !bypass_rt_o;
`else
  assign pend_rs = rs_used_i && rs_addr_i != '0 && cnt[rs_addr_i] != '0;
  assign pend_rt = rt_used_i && rt_addr_i != '0 && cnt[rt_addr_i] != '0;
`endif
  assign full    = issue_we_i && issue_dest_i != '0 && cnt[issue_dest_i] == '1;
  assign stall_o = issue_valid_i && (pend_rs || pend_rt || full);
  assign fire    = issue_valid_i && !stall_o && issue_we_i;
  always_ff @(posedge clk) sb_error_q <= reset ? 1'b0 : sb_error_q | (|uflow);
  assign sb_error_o = sb_error_q;
endmodule
